// File: rtl/psc_pkg.sv
// Shared types and helpers for the serial pattern scan controller.
package psc_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCAN   = 2'd1,
    REPORT = 2'd2
  } psc_state_t;

  // Limits a requested pattern length to the hardware maximum.
  function automatic logic [31:0] clamp_len(input logic [31:0] len, input logic [31:0] max_len);
    if (len > max_len) begin
      return max_len;
    end else begin
      return len;
    end
  endfunction

endpackage

// File: rtl/pattern_match_core.sv
// Bit history, saturating bits-seen counter and masked compare for an
// overlapping Mealy pattern matcher; hit is combinational on the incoming bit.
module pattern_match_core
  import psc_pkg::*;
#(
  parameter int PAT_MAX = 8,
  parameter int LEN_W   = $clog2(PAT_MAX + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               shift_en,
  input  logic               cur,
  input  logic [PAT_MAX-1:0] pat,
  input  logic [LEN_W-1:0]   len,
  output logic               hit
);

  logic [PAT_MAX-2:0] hist_r;
  logic [LEN_W-1:0]   bits_seen_r;
  logic [PAT_MAX-1:0] window_s;
  logic [PAT_MAX-1:0] mask_s;
  logic               enough_s;
  logic               hit_s;

  // Window of the most recent bits with the current bit in the LSB, and a
  // mask that keeps only the low len bits for comparison.
  always_comb begin
    window_s = {hist_r, cur};
    mask_s   = {PAT_MAX{1'b0}};
    for (int i = 0; i < PAT_MAX; i++) begin
      mask_s[i] = (i < int'(len));
    end
    enough_s = (({1'b0, bits_seen_r} + (LEN_W + 1)'(1)) >= {1'b0, len});
    if (shift_en && (len != {LEN_W{1'b0}}) && enough_s) begin
      hit_s = (((window_s ^ pat) & mask_s) == {PAT_MAX{1'b0}});
    end else begin
      hit_s = 1'b0;
    end
  end

  assign hit = hit_s;

  // History shift and bits-seen saturation, one step per scanned bit.
  always_ff @(posedge clk) begin
    if (!rst) begin
      hist_r      <= {(PAT_MAX - 1){1'b0}};
      bits_seen_r <= {LEN_W{1'b0}};
    end else if (clr) begin
      hist_r      <= {(PAT_MAX - 1){1'b0}};
      bits_seen_r <= {LEN_W{1'b0}};
    end else if (shift_en) begin
      hist_r <= window_s[PAT_MAX-2:0];
      if (bits_seen_r < LEN_W'(PAT_MAX)) begin
        bits_seen_r <= bits_seen_r + LEN_W'(1);
      end else begin
        bits_seen_r <= bits_seen_r;
      end
    end else begin
      hist_r      <= hist_r;
      bits_seen_r <= bits_seen_r;
    end
  end

endmodule

// File: rtl/pattern_scan_ctrl.sv
// Word-in / count-out sequencer around pattern_match_core. Define
// PSC_CARRY_HIST_EN to keep match history across words.
module pattern_scan_ctrl
  import psc_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int PAT_MAX = 8,
  parameter int LEN_W   = $clog2(PAT_MAX + 1),
  parameter int CNT_W   = $clog2(DATA_W + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [PAT_MAX-1:0] cfg_pat,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DATA_W-1:0]  in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [CNT_W-1:0]   out_count,
  output logic               hit,
  output logic               busy
);

  localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  psc_state_t         state_r;
  logic [IDX_W-1:0]   idx_r;
  logic [DATA_W-1:0]  word_r;
  logic [PAT_MAX-1:0] pat_r;
  logic [LEN_W-1:0]   len_r;
  logic [CNT_W-1:0]   count_r;
  logic               in_ready_r;
  logic               busy_r;
  logic               out_valid_r;
  logic [CNT_W-1:0]   out_count_r;
  logic               accept_s;
  logic               clr_s;
  logic               scan_s;
  logic               cur_s;
  logic               hit_s;

  assign accept_s = (state_r == IDLE) && in_valid && in_ready_r;
  assign scan_s   = (state_r == SCAN);
  assign cur_s    = word_r[idx_r];

`ifdef PSC_CARRY_HIST_EN
  assign clr_s = 1'b0;
`else
  assign clr_s = accept_s;
`endif

  pattern_match_core #(
    .PAT_MAX (PAT_MAX),
    .LEN_W   (LEN_W)
  ) u_core (
    .clk      (clk),
    .rst      (rst),
    .clr      (clr_s),
    .shift_en (scan_s),
    .cur      (cur_s),
    .pat      (pat_r),
    .len      (len_r),
    .hit      (hit_s)
  );

  // Sequencing FSM with registered handshake and status outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r     <= IDLE;
      idx_r       <= {IDX_W{1'b0}};
      word_r      <= {DATA_W{1'b0}};
      pat_r       <= {PAT_MAX{1'b0}};
      len_r       <= {LEN_W{1'b0}};
      count_r     <= {CNT_W{1'b0}};
      in_ready_r  <= 1'b1;
      busy_r      <= 1'b0;
      out_valid_r <= 1'b0;
      out_count_r <= {CNT_W{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            word_r     <= in_data;
            pat_r      <= cfg_pat;
            len_r      <= LEN_W'(clamp_len(32'(cfg_len), 32'(PAT_MAX)));
            count_r    <= {CNT_W{1'b0}};
            idx_r      <= IDX_W'(DATA_W - 1);
            in_ready_r <= 1'b0;
            busy_r     <= 1'b1;
            state_r    <= SCAN;
          end else begin
            in_ready_r <= 1'b1;
          end
        end
        SCAN: begin
          count_r <= count_r + CNT_W'(hit_s);
          if (idx_r == {IDX_W{1'b0}}) begin
            out_count_r <= count_r + CNT_W'(hit_s);
            out_valid_r <= 1'b1;
            state_r     <= REPORT;
          end else begin
            idx_r <= idx_r - IDX_W'(1);
          end
        end
        REPORT: begin
          if (out_ready) begin
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            in_ready_r  <= 1'b1;
            state_r     <= IDLE;
          end else begin
            out_valid_r <= 1'b1;
          end
        end
        default: begin
          state_r     <= IDLE;
          in_ready_r  <= 1'b1;
          busy_r      <= 1'b0;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign busy      = busy_r;
  assign out_valid = out_valid_r;
  assign out_count = out_count_r;
  assign hit       = hit_s;

endmodule
